code_lock_fsm: RTL and testbench

CODE_LOCK_FSM -- requirements
Module: code_lock_fsm

---
 rtl/code_lock_fsm.sv | 213 +++++++++++++++++++++
 tb/tb_code_lock_fsm.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_lock_fsm.sv
// -----------------------------------------------------------------------------
// code_lock_fsm
//
// Four-digit code lock. A 16-bit secret code (four 4-bit digits, first digit
// in [15:12]) is loaded while idle. Digits are entered one per accepted
// handshake. All four digits are always consumed before the attempt is judged.
// A correct attempt opens the unlocked window for UNLOCK_CYCLES cycles. A wrong
// attempt pulses fail_pulse and bumps the consecutive-failure count. Reaching
// MAX_FAILS failures forces a lockout of LOCKOUT_CYCLES cycles.
//
// Parameters
//   UNLOCK_CYCLES  : cycles unlocked is held high          (1..255)
//   LOCKOUT_CYCLES : cycles locked_out is held high        (1..255)
//   MAX_FAILS      : consecutive failures before lockout   (1..3)
//
// Ports
//   clk          in   single clock, rising edge
//   reset        in   synchronous, active-high reset
//   code_load    in   store code_in as the secret (honoured only when idle)
//   code_in      in   [15:0] new secret code
//   digit_valid  in   entered digit is valid this cycle
//   digit        in   [3:0] entered digit value
//   digit_ready  out  block accepts a digit this cycle (state decode only)
//   unlocked     out  high while the code-accepted window is open
//   locked_out   out  high while in lockout
//   fail_pulse   out  one-cycle pulse per failed attempt
//   fail_count   out  [1:0] consecutive failed attempts (saturates at 3)
//
// Every output is either a register or a decode of the state register, so
// there is no combinational path from any input to any output.
// -----------------------------------------------------------------------------
module code_lock_fsm #(
  parameter int UNLOCK_CYCLES  = 8,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int MAX_FAILS      = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        code_load,
  input  logic [15:0] code_in,
  input  logic        digit_valid,
  input  logic [3:0]  digit,
  output logic        digit_ready,
  output logic        unlocked,
  output logic        locked_out,
  output logic        fail_pulse,
  output logic [1:0]  fail_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENTER   = 2'd1,
    ST_UNLOCK  = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  // The dwell counter counts down to zero, so it is loaded with N-1 to
  // give exactly N cycles in the dwelling state.
  localparam logic [7:0] UNLOCK_LOAD  = 8'(UNLOCK_CYCLES - 1);
  localparam logic [7:0] LOCKOUT_LOAD = 8'(LOCKOUT_CYCLES - 1);
  localparam logic [1:0] FAIL_LIMIT   = 2'(MAX_FAILS);

  // Registered state
  state_t      r_state;
  logic [15:0] r_code;
  logic [1:0]  r_idx;
  logic        r_mismatch;
  logic [7:0]  r_dwell;
  logic [1:0]  r_fail_count;
  logic        r_fail_pulse;

  // Next-state values
  state_t      w_state_next;
  logic [15:0] w_code_next;
  logic [1:0]  w_idx_next;
  logic        w_mismatch_next;
  logic [7:0]  w_dwell_next;
  logic [1:0]  w_fail_count_next;
  logic        w_fail_pulse_next;

  // Datapath helpers
  logic [3:0]  w_nibble [4];
  logic [3:0]  w_sel_nibble;
  logic        w_digit_miss;
  logic        w_attempt_bad;
  logic [1:0]  w_fails_inc;

  // Split the stored code into digits; index 0 is the first digit entered.
  for (genvar gi = 0; gi < 4; gi++) begin : g_nibble
    assign w_nibble[gi] = r_code[15 - 4*gi -: 4];
  end

  // The index is held at 0 in IDLE, so the same select covers the first digit.
  assign w_sel_nibble  = w_nibble[r_idx];
  assign w_digit_miss  = (digit != w_sel_nibble);
  assign w_attempt_bad = r_mismatch | w_digit_miss;
  assign w_fails_inc   = (r_fail_count == 2'd3) ? 2'd3 : (r_fail_count + 2'd1);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_code       <= 16'h0000;
      r_idx        <= 2'd0;
      r_mismatch   <= 1'b0;
      r_dwell      <= 8'd0;
      r_fail_count <= 2'd0;
      r_fail_pulse <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_code       <= w_code_next;
      r_idx        <= w_idx_next;
      r_mismatch   <= w_mismatch_next;
      r_dwell      <= w_dwell_next;
      r_fail_count <= w_fail_count_next;
      r_fail_pulse <= w_fail_pulse_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next      = r_state;
    w_code_next       = r_code;
    w_idx_next        = r_idx;
    w_mismatch_next   = r_mismatch;
    w_dwell_next      = r_dwell;
    w_fail_count_next = r_fail_count;
    w_fail_pulse_next = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // A load takes priority; a digit presented on the same edge is dropped.
        if (code_load) begin
          w_code_next = code_in;
        end else if (digit_valid) begin
          w_state_next    = ST_ENTER;
          w_idx_next      = 2'd1;
          w_mismatch_next = w_digit_miss;
        end
      end

      ST_ENTER: begin
        // code_load is deliberately ignored here.
        if (digit_valid) begin
          if (r_idx == 2'd3) begin
            // Fourth digit: judge the whole attempt.
            w_idx_next      = 2'd0;
            w_mismatch_next = 1'b0;
            if (!w_attempt_bad) begin
              w_state_next      = ST_UNLOCK;
              w_dwell_next      = UNLOCK_LOAD;
              w_fail_count_next = 2'd0;
            end else begin
              w_fail_pulse_next = 1'b1;
              w_fail_count_next = w_fails_inc;
              if (w_fails_inc >= FAIL_LIMIT) begin
                w_state_next = ST_LOCKOUT;
                w_dwell_next = LOCKOUT_LOAD;
              end else begin
                w_state_next = ST_IDLE;
              end
            end
          end else begin
            // A mismatch is remembered, never acted on early.
            w_idx_next      = r_idx + 2'd1;
            w_mismatch_next = w_attempt_bad;
          end
        end
      end

      ST_UNLOCK: begin
        if (r_dwell == 8'd0) begin
          w_state_next    = ST_IDLE;
          w_idx_next      = 2'd0;
          w_mismatch_next = 1'b0;
        end else begin
          w_dwell_next = r_dwell - 8'd1;
        end
      end

      ST_LOCKOUT: begin
        if (r_dwell == 8'd0) begin
          w_state_next      = ST_IDLE;
          w_idx_next        = 2'd0;
          w_mismatch_next   = 1'b0;
          w_fail_count_next = 2'd0;
        end else begin
          w_dwell_next = r_dwell - 8'd1;
        end
      end

      default: begin
        w_state_next    = ST_IDLE;
        w_idx_next      = 2'd0;
        w_mismatch_next = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: state decodes and registers only
  // ---------------------------------------------------------------------------
  assign digit_ready = (r_state == ST_IDLE) || (r_state == ST_ENTER);
  assign unlocked    = (r_state == ST_UNLOCK);
  assign locked_out  = (r_state == ST_LOCKOUT);
  assign fail_pulse  = r_fail_pulse;
  assign fail_count  = r_fail_count;

endmodule

// File: tb/tb_code_lock_fsm.sv
// -----------------------------------------------------------------------------
// tb_code_lock_fsm
//
// Self-checking bench for code_lock_fsm. A behavioural model keeps the secret
// code, a queue of digits entered so far in the current attempt, the failure
// count and the remaining unlock / lockout time. After every clock edge each
// scenario compares the DUT outputs with the model, and adds
// scenario-specific checks for the directed cases.
// -----------------------------------------------------------------------------
module tb_code_lock_fsm;

  localparam int UNLOCK_CYCLES  = 8;
  localparam int LOCKOUT_CYCLES = 16;
  localparam int MAX_FAILS      = 3;

  logic        clk;
  logic        reset;
  logic        code_load;
  logic [15:0] code_in;
  logic        digit_valid;
  logic [3:0]  digit;
  logic        digit_ready;
  logic        unlocked;
  logic        locked_out;
  logic        fail_pulse;
  logic [1:0]  fail_count;

  logic [5:0]  dut_v;
  assign dut_v = {digit_ready, unlocked, locked_out, fail_pulse, fail_count};

  int checks   = 0;
  int failures = 0;

  code_lock_fsm #(
    .UNLOCK_CYCLES (UNLOCK_CYCLES),
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES),
    .MAX_FAILS     (MAX_FAILS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .code_load  (code_load),
    .code_in    (code_in),
    .digit_valid(digit_valid),
    .digit      (digit),
    .digit_ready(digit_ready),
    .unlocked   (unlocked),
    .locked_out (locked_out),
    .fail_pulse (fail_pulse),
    .fail_count (fail_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [15:0] m_code;
  logic [3:0]  m_digits [$];
  int          m_unlock_left;
  int          m_lock_left;
  int          m_fails;
  logic        m_pulse;

  function automatic logic [5:0] model_outs();
    logic busy;
    busy = (m_unlock_left > 0) || (m_lock_left > 0);
    return {!busy, (m_unlock_left > 0), (m_lock_left > 0), m_pulse, 2'(m_fails)};
  endfunction

  function automatic logic [3:0] model_next_digit();
    int k;
    k = m_digits.size();
    return m_code[15 - 4*k -: 4];
  endfunction

  task automatic model_step(input logic rst, input logic ld, input logic [15:0] cin,
                            input logic vld, input logic [3:0] d);
    logic [15:0] entered;
    m_pulse = 1'b0;
    if (rst) begin
      m_code = 16'h0000;
      m_digits.delete();
      m_unlock_left = 0;
      m_lock_left   = 0;
      m_fails       = 0;
    end else if (m_unlock_left > 0) begin
      m_unlock_left--;
    end else if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fails = 0;
    end else if (ld && m_digits.size() == 0) begin
      m_code = cin;
    end else if (vld) begin
      m_digits.push_back(d);
      if (m_digits.size() == 4) begin
        entered = {m_digits[0], m_digits[1], m_digits[2], m_digits[3]};
        if (entered == m_code) begin
          m_unlock_left = UNLOCK_CYCLES;
          m_fails       = 0;
          $display("attempt entered=%h code=%h -> opened", entered, m_code);
        end else begin
          m_pulse = 1'b1;
          if (m_fails < 3) m_fails++;
          if (m_fails == MAX_FAILS) m_lock_left = LOCKOUT_CYCLES;
          $display("attempt entered=%h code=%h -> rejected, fails=%0d", entered, m_code, m_fails);
        end
        m_digits.delete();
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, advance the model, sample 1 time
  // unit after the edge.
  task automatic tick(input logic rst, input logic ld, input logic [15:0] cin,
                      input logic vld, input logic [3:0] d);
    reset       = rst;
    code_load   = ld;
    code_in     = cin;
    digit_valid = vld;
    digit       = d;
    @(posedge clk);
    model_step(rst, ld, cin, vld, d);
    #1;
    reset       = 1'b0;
    code_load   = 1'b0;
    digit_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    tick(1'b1, 1'b0, 16'h0, 1'b0, 4'h0);
    checks++;
    if (dut_v !== 6'b100000) begin
      failures++;
      $display("FAIL reset_state: got %b expected %b", dut_v, 6'b100000);
    end
    tick(1'b0, 1'b0, 16'h0, 1'b0, 4'h0);
    checks++;
    if (dut_v !== model_outs()) begin
      failures++;
      $display("FAIL reset_idle: got %b expected %b", dut_v, model_outs());
    end
  endtask

  task automatic test_unlock();
    logic [15:0] seq;
    int unl = 0;
    int pulses = 0;
    seq = 16'h1A2F;
    tick(1'b1, 1'b0, 16'h0, 1'b0, 4'h0);
    tick(1'b0, 1'b1, 16'h1A2F, 1'b0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 16'h0, 1'b1, seq[15 - 4*i -: 4]);
      checks++;
      if (dut_v !== model_outs()) begin
        failures++;
        $display("FAIL unlock_digit%0d: got %b expected %b", i, dut_v, model_outs());
      end
      if (fail_pulse) pulses++;
    end
    checks++;
    if (unlocked !== 1'b1) begin
      failures++;
      $display("FAIL unlock_first_cycle: got %b expected 1", unlocked);
    end
    unl = 1;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, 16'h0, 1'b0, 4'h0);
      checks++;
      if (dut_v !== model_outs()) begin
        failures++;
        $display("FAIL unlock_hold%0d: got %b expected %b", i, dut_v, model_outs());
      end
      if (unlocked) unl++;
      if (fail_pulse) pulses++;
    end
    checks++;
    if (unl != 8 || pulses != 0 || fail_count !== 2'd0) begin
      failures++;
      $display("FAIL unlock_window: got cycles=%0d pulses=%0d fc=%0d expected 8/0/0",
               unl, pulses, fail_count);
    end
  endtask

  task automatic test_wrong();
    logic [15:0] seq;
    seq = 16'h1A2E;
    tick(1'b1, 1'b0, 16'h0, 1'b0, 4'h0);
    tick(1'b0, 1'b1, 16'h1A2F, 1'b0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 16'h0, 1'b1, seq[15 - 4*i -: 4]);
      checks++;
      if (dut_v !== model_outs()) begin
        failures++;
        $display("FAIL wrong_digit%0d: got %b expected %b", i, dut_v, model_outs());
      end
    end
    checks++;
    if (dut_v !== 6'b100101) begin
      failures++;
      $display("FAIL wrong_result: got %b expected %b", dut_v, 6'b100101);
    end
    tick(1'b0, 1'b0, 16'h0, 1'b0, 4'h0);
    checks++;
    if (dut_v !== 6'b100001) begin
      failures++;
      $display("FAIL wrong_pulse_end: got %b expected %b", dut_v, 6'b100001);
    end
  endtask

  task automatic test_lockout();
    logic [15:0] bad [3];
    logic [15:0] good;
    int locked = 0;
    bad[0] = 16'h1A2E;
    bad[1] = 16'h0000;
    bad[2] = 16'hFFFF;
    good   = 16'h1A2F;
    tick(1'b1, 1'b0, 16'h0, 1'b0, 4'h0);
    tick(1'b0, 1'b1, 16'h1A2F, 1'b0, 4'h0);
    for (int a = 0; a < 3; a++) begin
      for (int i = 0; i < 4; i++) begin
        tick(1'b0, 1'b0, 16'h0, 1'b1, bad[a][15 - 4*i -: 4]);
        checks++;
        if (dut_v !== model_outs()) begin
          failures++;
          $display("FAIL lockout_try%0d_digit%0d: got %b expected %b", a, i, dut_v, model_outs());
        end
      end
    end
    checks++;
    if (locked_out !== 1'b1 || fail_count !== 2'd3 || digit_ready !== 1'b0) begin
      failures++;
      $display("FAIL lockout_entry: got lo=%b fc=%0d rdy=%b expected 1/3/0",
               locked_out, fail_count, digit_ready);
    end
    locked = 1;
    // Keep offering correct digits; none may be taken during lockout.
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b0, 16'h0, 1'b1, good[15 - 4*(i % 4) -: 4]);
      checks++;
      if (dut_v !== model_outs()) begin
        failures++;
        $display("FAIL lockout_hold%0d: got %b expected %b", i, dut_v, model_outs());
      end
      if (locked_out) locked++;
      if (i == 15) break;
    end
    checks++;
    if (locked != 16 || fail_count !== 2'd0 || digit_ready !== 1'b1) begin
      failures++;
      $display("FAIL lockout_exit: got cycles=%0d fc=%0d rdy=%b expected 16/0/1",
               locked, fail_count, digit_ready);
    end
  endtask

  task automatic test_load_priority();
    tick(1'b1, 1'b0, 16'h0, 1'b0, 4'h0);
    tick(1'b0, 1'b1, 16'hC0DE, 1'b1, 4'hC);
    tick(1'b0, 1'b0, 16'h0, 1'b1, 4'hC);
    tick(1'b0, 1'b0, 16'h0, 1'b1, 4'h0);
    tick(1'b0, 1'b1, 16'hFFFF, 1'b0, 4'h0);
    checks++;
    if (dut_v !== model_outs()) begin
      failures++;
      $display("FAIL load_in_enter: got %b expected %b", dut_v, model_outs());
    end
    tick(1'b0, 1'b0, 16'h0, 1'b1, 4'hD);
    tick(1'b0, 1'b0, 16'h0, 1'b1, 4'hE);
    checks++;
    if (unlocked !== 1'b1 || dut_v !== model_outs()) begin
      failures++;
      $display("FAIL load_priority: got %b expected %b", dut_v, model_outs());
    end
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 1'b0, 16'h0, 1'b0, 4'h0);
    tick(1'b0, 1'b1, 16'h1A2F, 1'b0, 4'h0);
    tick(1'b0, 1'b0, 16'h0, 1'b1, 4'h1);
    tick(1'b0, 1'b0, 16'h0, 1'b1, 4'hA);
    tick(1'b1, 1'b0, 16'h0, 1'b0, 4'h0);
    checks++;
    if (dut_v !== 6'b100000) begin
      failures++;
      $display("FAIL reset_mid_entry: got %b expected %b", dut_v, 6'b100000);
    end
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 16'h0, 1'b1, 4'h0);
    checks++;
    if (unlocked !== 1'b1 || dut_v !== model_outs()) begin
      failures++;
      $display("FAIL reset_code_zero: got %b expected %b", dut_v, model_outs());
    end
    tick(1'b0, 1'b0, 16'h0, 1'b0, 4'h0);
    tick(1'b1, 1'b0, 16'h0, 1'b0, 4'h0);
    checks++;
    if (dut_v !== 6'b100000) begin
      failures++;
      $display("FAIL reset_mid_unlock: got %b expected %b", dut_v, 6'b100000);
    end
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b0, 16'h0, 1'b1, 4'h1);
    tick(1'b0, 1'b0, 16'h0, 1'b0, 4'h0);
    checks++;
    if (locked_out !== 1'b1 || dut_v !== model_outs()) begin
      failures++;
      $display("FAIL reset_pre_lockout: got %b expected %b", dut_v, model_outs());
    end
    tick(1'b1, 1'b0, 16'h0, 1'b0, 4'h0);
    checks++;
    if (dut_v !== 6'b100000) begin
      failures++;
      $display("FAIL reset_mid_lockout: got %b expected %b", dut_v, 6'b100000);
    end
  endtask

  task automatic test_gaps();
    logic [15:0] seq [2];
    seq[0] = 16'h1A2F;
    seq[1] = 16'h1B2F;
    tick(1'b1, 1'b0, 16'h0, 1'b0, 4'h0);
    tick(1'b0, 1'b1, 16'h1A2F, 1'b0, 4'h0);
    for (int a = 0; a < 2; a++) begin
      for (int i = 0; i < 4; i++) begin
        int gap;
        gap = int'($urandom_range(3, 0));
        for (int g = 0; g < gap; g++) begin
          tick(1'b0, 1'b0, 16'h0, 1'b0, 4'($urandom));
          checks++;
          if (dut_v !== model_outs()) begin
            failures++;
            $display("FAIL gaps_idle: got %b expected %b", dut_v, model_outs());
          end
        end
        tick(1'b0, 1'b0, 16'h0, 1'b1, seq[a][15 - 4*i -: 4]);
        checks++;
        if (dut_v !== model_outs()) begin
          failures++;
          $display("FAIL gaps_digit: got %b expected %b", dut_v, model_outs());
        end
      end
      checks++;
      if (a == 0 && unlocked !== 1'b1) begin
        failures++;
        $display("FAIL gaps_unlock: got %b expected 1", unlocked);
      end else if (a == 1 && fail_pulse !== 1'b1) begin
        failures++;
        $display("FAIL gaps_reject: got %b expected 1", fail_pulse);
      end
      for (int i = 0; i < UNLOCK_CYCLES; i++) tick(1'b0, 1'b0, 16'h0, 1'b0, 4'h0);
    end
  endtask

  task automatic test_random();
    logic [15:0] codes [4];
    codes[0] = 16'h1A2F;
    codes[1] = 16'h0000;
    codes[2] = 16'hBEEF;
    codes[3] = 16'h7777;
    tick(1'b1, 1'b0, 16'h0, 1'b0, 4'h0);
    for (int n = 0; n < 3000; n++) begin
      logic rst, ld, vld;
      logic [3:0] d;
      rst = ($urandom_range(199, 0) == 0);
      ld  = ($urandom_range(19, 0) == 0);
      vld = ($urandom_range(1, 0) == 1);
      d   = ($urandom_range(3, 0) != 0) ? model_next_digit() : 4'($urandom);
      tick(rst, ld, codes[$urandom_range(3, 0)], vld, d);
      checks++;
      if (dut_v !== model_outs()) begin
        failures++;
        $display("FAIL random_cycle%0d: got %b expected %b", n, dut_v, model_outs());
      end
    end
  endtask

  initial begin
    reset       = 1'b0;
    code_load   = 1'b0;
    code_in     = 16'h0;
    digit_valid = 1'b0;
    digit       = 4'h0;
    m_code        = 16'h0;
    m_unlock_left = 0;
    m_lock_left   = 0;
    m_fails       = 0;
    m_pulse       = 1'b0;
    #2;
    test_reset();
    test_unlock();
    test_wrong();
    test_lockout();
    test_load_priority();
    test_reset_mid();
    test_gaps();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
